// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register sequencer: command ops,
// mux select codes and controller state encoding.
package usr_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/usr_seq_ctrl_if.sv
// Host/datapath-facing bundle of the sequencer: command handshake, serial
// inputs, mux selects, register contents and status.
interface usr_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [WIDTH-1:0] cmd_data;
    logic             sr_in;
    logic             sl_in;
    logic             s1;
    logic             s0;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_data, sr_in, sl_in,
        output cmd_ready, s1, s0, q, busy, done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_data, sr_in, sl_in,
        input  cmd_ready, s1, s0, q, busy, done
    );

endinterface

// File: rtl/usr_datapath.sv
// WIDTH bit cells, each a 4:1 mux (hold / shift right / shift left / load)
// feeding a D flip-flop with asynchronous active-high reset.
module usr_datapath
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel_i,
    input  logic             sr_in_i,
    input  logic             sl_in_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] shr_src;
    logic [WIDTH-1:0] shl_src;

    // Per-cell neighbour taps; the serial inputs fill the vacated end bit.
    assign shr_src = {sr_in_i, q_q[WIDTH-1:1]};
    assign shl_src = {q_q[WIDTH-2:0], sl_in_i};

    always_comb begin
        q_d = q_q;
        for (int i = 0; i < WIDTH; i++) begin
            unique case (sel_i)
                SEL_HOLD: q_d[i] = q_q[i];
                SEL_SHR:  q_d[i] = shr_src[i];
                SEL_SHL:  q_d[i] = shl_src[i];
                default:  q_d[i] = data_i[i];
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as a real shift chain does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/usr_seq_ctrl.sv
// Command sequencer for a universal shift register: accepts one command at a
// time and drives the shared mux selects. Optional rotate mode: USR_ROTATE_EN.
module usr_seq_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    usr_seq_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_in;
    logic [WIDTH-1:0] q_w;
    logic [1:0]       sel;
    logic             sr_eff;
    logic             sl_eff;
    logic             ready;
    logic             busy;
    logic             done;

`ifdef USR_ROTATE_EN
    logic rot_q, rot_d;
    logic rot_in;

    // The count MSB requests rotation; the remaining bits are the count.
    assign cnt_in = {1'b0, bus.cmd_cnt[CNT_W-2:0]};
    assign rot_in = bus.cmd_cnt[CNT_W-1];
    assign sr_eff = rot_q ? q_w[0]       : bus.sr_in;
    assign sl_eff = rot_q ? q_w[WIDTH-1] : bus.sl_in;
`else
    assign cnt_in = bus.cmd_cnt;
    assign sr_eff = bus.sr_in;
    assign sl_eff = bus.sl_in;
`endif

    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
`ifdef USR_ROTATE_EN
        rot_d   = rot_q;
`endif
        sel     = SEL_HOLD;
        ready   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (bus.cmd_valid) begin
                    op_d   = bus.cmd_op;
                    cnt_d  = cnt_in;
                    data_d = bus.cmd_data;
`ifdef USR_ROTATE_EN
                    rot_d  = rot_in;
`endif
                    unique case (bus.cmd_op)
                        OP_LOAD: state_d = ST_LOAD;
                        OP_SHR, OP_SHL:
                            state_d = (cnt_in != '0) ? ST_SHIFT : ST_DONE;
                        OP_HOLD: state_d = ST_DONE;
                        default: state_d = ST_DONE;
                    endcase
                end
            end
            ST_LOAD: begin
                sel     = SEL_LOAD;
                state_d = ST_DONE;
            end
            ST_SHIFT: begin
                // Op codes for the two shifts coincide with their select codes.
                sel   = op_q;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: all controller registers are few and cheap, so all are reset to
    // keep the post-reset state fully defined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

`ifdef USR_ROTATE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rot_q <= 1'b0;
        end else begin
            rot_q <= rot_d;
        end
    end
`endif

    usr_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .sel_i   (sel),
        .sr_in_i (sr_eff),
        .sl_in_i (sl_eff),
        .data_i  (data_q),
        .q_o     (q_w)
    );

    assign bus.cmd_ready = ready;
    assign bus.s1        = sel[1];
    assign bus.s0        = sel[0];
    assign bus.q         = q_w;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Directed self-checking bench for usr_seq_ctrl; inputs change and outputs are
// sampled on the falling clock edge.
module tb_usr_seq_ctrl;
    import usr_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
`ifdef USR_ROTATE_EN
    localparam logic [CNT_W-1:0] LONG_CNT = 3'd3;
`else
    localparam logic [CNT_W-1:0] LONG_CNT = 3'd5;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    usr_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    usr_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_st(input string tag, input logic [1:0] sel, input logic rdy,
                             input logic bsy, input logic dn, input logic [WIDTH-1:0] qv);
        check({tag, ".sel"},   {30'd0, bus.s1, bus.s0}, {30'd0, sel});
        check({tag, ".ready"}, {31'd0, bus.cmd_ready}, {31'd0, rdy});
        check({tag, ".busy"},  {31'd0, bus.busy}, {31'd0, bsy});
        check({tag, ".done"},  {31'd0, bus.done}, {31'd0, dn});
        check({tag, ".q"},     {28'd0, bus.q}, {28'd0, qv});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                         input logic [WIDTH-1:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_cnt   = cnt;
        bus.cmd_data  = data;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] data);
        issue(OP_LOAD, '0, data);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_HOLD;
        bus.cmd_cnt   = '0;
        bus.cmd_data  = '0;
        bus.sr_in     = 1'b0;
        bus.sl_in     = 1'b0;

        // Reset asserted mid-cycle, released on a falling edge.
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        expect_st("reset", SEL_HOLD, 1'b1, 1'b0, 1'b0, 4'b0000);
        rst = 1'b0;
        tick();

        // Parallel load; data changed after acceptance must not matter.
        issue(OP_LOAD, '0, 4'b1011);
        check("load.accept_ready", {31'd0, bus.cmd_ready}, 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 4'b0000;
        expect_st("load.e0", SEL_LOAD, 1'b0, 1'b1, 1'b0, 4'b0000);
        tick();
        expect_st("load.e1", SEL_HOLD, 1'b0, 1'b1, 1'b1, 4'b1011);
        tick();
        expect_st("load.idle", SEL_HOLD, 1'b1, 1'b0, 1'b0, 4'b1011);

        // Shift right 2 with sr_in=1: 1011 -> 1101 -> 1110.
        bus.sr_in = 1'b1;
        issue(OP_SHR, 3'd2, '0);
        tick();
        bus.cmd_valid = 1'b0;
        expect_st("shr.e0", SEL_SHR, 1'b0, 1'b1, 1'b0, 4'b1011);
        tick();
        expect_st("shr.e1", SEL_SHR, 1'b0, 1'b1, 1'b0, 4'b1101);
        tick();
        expect_st("shr.e2", SEL_HOLD, 1'b0, 1'b1, 1'b1, 4'b1110);
        tick();
        expect_st("shr.idle", SEL_HOLD, 1'b1, 1'b0, 1'b0, 4'b1110);

        // Shift left 3 with sl_in=0: 0011 -> 0110 -> 1100 -> 1000.
        do_load(4'b0011);
        check("shl.preload", {28'd0, bus.q}, 32'h3);
        bus.sl_in = 1'b0;
        issue(OP_SHL, 3'd3, '0);
        tick();
        bus.cmd_valid = 1'b0;
        expect_st("shl.e0", SEL_SHL, 1'b0, 1'b1, 1'b0, 4'b0011);
        tick();
        expect_st("shl.e1", SEL_SHL, 1'b0, 1'b1, 1'b0, 4'b0110);
        tick();
        expect_st("shl.e2", SEL_SHL, 1'b0, 1'b1, 1'b0, 4'b1100);
        tick();
        expect_st("shl.e3", SEL_HOLD, 1'b0, 1'b1, 1'b1, 4'b1000);
        tick();
        expect_st("shl.idle", SEL_HOLD, 1'b1, 1'b0, 1'b0, 4'b1000);

        // Degenerate commands finish in the cycle after acceptance.
        issue(OP_HOLD, 3'd4, 4'b1111);
        tick();
        bus.cmd_valid = 1'b0;
        expect_st("hold.e0", SEL_HOLD, 1'b0, 1'b1, 1'b1, 4'b1000);
        tick();
        expect_st("hold.idle", SEL_HOLD, 1'b1, 1'b0, 1'b0, 4'b1000);
        issue(OP_SHR, 3'd0, '0);
        tick();
        bus.cmd_valid = 1'b0;
        expect_st("cnt0.e0", SEL_HOLD, 1'b0, 1'b1, 1'b1, 4'b1000);
        tick();
        expect_st("cnt0.idle", SEL_HOLD, 1'b1, 1'b0, 1'b0, 4'b1000);

        // Back-to-back: second command held while busy, taken at first IDLE edge.
        bus.sr_in = 1'b0;
        issue(OP_SHR, 3'd2, '0);
        tick();
        issue(OP_SHL, 3'd1, '0);
        bus.sl_in = 1'b1;
        expect_st("b2b.e0", SEL_SHR, 1'b0, 1'b1, 1'b0, 4'b1000);
        tick();
        expect_st("b2b.e1", SEL_SHR, 1'b0, 1'b1, 1'b0, 4'b0100);
        tick();
        expect_st("b2b.e2", SEL_HOLD, 1'b0, 1'b1, 1'b1, 4'b0010);
        tick();
        expect_st("b2b.idle", SEL_HOLD, 1'b1, 1'b0, 1'b0, 4'b0010);
        tick();
        bus.cmd_valid = 1'b0;
        expect_st("b2b.second_e0", SEL_SHL, 1'b0, 1'b1, 1'b0, 4'b0010);
        tick();
        expect_st("b2b.second_e1", SEL_HOLD, 1'b0, 1'b1, 1'b1, 4'b0101);
        tick();
        expect_st("b2b.second_idle", SEL_HOLD, 1'b1, 1'b0, 1'b0, 4'b0101);

        // Reset during a long shift after two shift edges.
        bus.sr_in = 1'b1;
        issue(OP_SHR, LONG_CNT, '0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        check("rstmid.e1.q", {28'd0, bus.q}, 32'b1010);
        tick();
        expect_st("rstmid.e2", SEL_SHR, 1'b0, 1'b1, 1'b0, 4'b1101);
        rst = 1'b1;
        #1;
        expect_st("rstmid.async", SEL_HOLD, 1'b1, 1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_st($sformatf("rstmid.after%0d", i), SEL_HOLD, 1'b1, 1'b0, 1'b0, 4'b0000);
        end

`ifdef USR_ROTATE_EN
        // Rotate left by one: 1001 -> 0011, serial input ignored.
        do_load(4'b1001);
        bus.sl_in = 1'b0;
        issue(OP_SHL, 3'b101, '0);
        tick();
        bus.cmd_valid = 1'b0;
        expect_st("rot.e0", SEL_SHL, 1'b0, 1'b1, 1'b0, 4'b1001);
        tick();
        expect_st("rot.e1", SEL_HOLD, 1'b0, 1'b1, 1'b1, 4'b0011);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
